// File: rtl/cnn_pkg.sv
// Shared types for the layer sequencer: FSM state encoding and layer-index width.
package cnn_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_WAIT   = 3'd2,
    S_DONE   = 3'd3,
    S_ERR    = 3'd4
  } state_t;

  // A single-layer build still needs a 1-bit index.
  function automatic int layer_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cnn_next_layer_sel.sv
// Priority finder: lowest enabled layer strictly above cur, or lowest enabled overall.
module cnn_next_layer_sel #(
  parameter int NUM_LAYERS = 3,
  parameter int LAYER_W    = 2
) (
  input  logic [NUM_LAYERS-1:0] mask,
  input  logic [LAYER_W-1:0]    cur,
  input  logic                  from_start,
  output logic [LAYER_W-1:0]    idx,
  output logic                  found
);

  // Scan downwards so the lowest qualifying index is the last one written.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (mask[i] && (from_start || (LAYER_W'(i) > cur))) begin
        idx   = LAYER_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cnn_layer_sequencer.sv
// Sequences NUM_LAYERS layer engines via start-pulse/done handshake, with bypass,
// per-layer watchdog, abort, continuous mode and a completed-frame counter.
module cnn_layer_sequencer
  import cnn_pkg::*;
#(
  parameter  int NUM_LAYERS = 3,
  parameter  int TMO_W      = 16,
  parameter  int FCNT_W     = 16,
  localparam int LAYER_W    = layer_w(NUM_LAYERS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  cont_mode,
  input  logic [NUM_LAYERS-1:0] bypass,
  input  logic [TMO_W-1:0]      timeout_limit,
  input  logic [NUM_LAYERS-1:0] layer_done,
  output logic [NUM_LAYERS-1:0] layer_start,
  output logic [LAYER_W-1:0]    cur_layer,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [LAYER_W-1:0]    err_layer,
  output logic [FCNT_W-1:0]     frame_count
);

  state_t                state;
  logic [NUM_LAYERS-1:0] byp_q;
  logic [TMO_W-1:0]      timer;
  logic [LAYER_W-1:0]    first_idx, next_idx;
  logic                  first_found, next_found;
  logic                  go, cur_done, tmo_hit;

  function automatic logic [NUM_LAYERS-1:0] onehot(input logic [LAYER_W-1:0] i);
    onehot    = '0;
    onehot[i] = 1'b1;
  endfunction

  // Launch looks at the live bypass input; advance uses the mask latched for this frame.
  cnn_next_layer_sel #(.NUM_LAYERS(NUM_LAYERS), .LAYER_W(LAYER_W)) u_first (
    .mask       (~bypass),
    .cur        ('0),
    .from_start (1'b1),
    .idx        (first_idx),
    .found      (first_found)
  );

  cnn_next_layer_sel #(.NUM_LAYERS(NUM_LAYERS), .LAYER_W(LAYER_W)) u_next (
    .mask       (~byp_q),
    .cur        (cur_layer),
    .from_start (1'b0),
    .idx        (next_idx),
    .found      (next_found)
  );

  assign go       = ((state == S_IDLE) && start) || ((state == S_DONE) && cont_mode);
  assign cur_done = layer_done[cur_layer];
  assign tmo_hit  = (timeout_limit != '0) && (timer == timeout_limit - TMO_W'(1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_IDLE;
      byp_q       <= '0;
      timer       <= '0;
      layer_start <= '0;
      cur_layer   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      err_layer   <= '0;
      frame_count <= '0;
    end else begin
      layer_start <= '0;
      done        <= 1'b0;
      if (abort) begin
        state     <= S_IDLE;
        busy      <= 1'b0;
        error     <= 1'b0;
        err_layer <= '0;
      end else if (go) begin
        byp_q <= bypass;
        busy  <= 1'b1;
        if (first_found) begin
          cur_layer   <= first_idx;
          layer_start <= onehot(first_idx);
          state       <= S_LAUNCH;
        end else begin
          state       <= S_DONE;
          done        <= 1'b1;
          frame_count <= frame_count + FCNT_W'(1);
        end
      end else begin
        case (state)
          S_LAUNCH: begin
            state <= S_WAIT;
            timer <= '0;
          end
          S_WAIT: begin
            if (timer != '1) timer <= timer + TMO_W'(1);
            // A done arriving on the last allowed cycle still counts as success.
            if (cur_done) begin
              if (next_found) begin
                cur_layer   <= next_idx;
                layer_start <= onehot(next_idx);
                state       <= S_LAUNCH;
              end else begin
                state       <= S_DONE;
                done        <= 1'b1;
                frame_count <= frame_count + FCNT_W'(1);
              end
            end else if (tmo_hit) begin
              state     <= S_ERR;
              busy      <= 1'b0;
              error     <= 1'b1;
              err_layer <= cur_layer;
            end
          end
          S_DONE: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Self-checking bench: vector table, hand sequences and random frames vs a timing model.
module tb_cnn_layer_sequencer;
  localparam int NL = 3;
  localparam int LW = 2;
  localparam int TW = 16;
  localparam int FW = 16;

  logic          clk = 1'b0;
  logic          rst, start, abort, cont_mode;
  logic [NL-1:0] bypass, layer_done, layer_start;
  logic [TW-1:0] timeout_limit;
  logic [LW-1:0] cur_layer, err_layer;
  logic          busy, done, error;
  logic [FW-1:0] frame_count;

  cnn_layer_sequencer #(.NUM_LAYERS(NL), .TMO_W(TW), .FCNT_W(FW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .cont_mode(cont_mode),
    .bypass(bypass), .timeout_limit(timeout_limit), .layer_done(layer_done),
    .layer_start(layer_start), .cur_layer(cur_layer), .busy(busy), .done(done),
    .error(error), .err_layer(err_layer), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;
  int cyc, err_cyc, err_l, spur_cyc;
  logic [2:0] spur_bits, hang;
  bit busy_drop, onehot_bad, curl_bad;
  int cnt[NL], dly[NL];
  int st_l[$], st_c[$], done_q[$];
  int exp_l[$], exp_c[$];
  int exp_dc, exp_ec, exp_el, exp_fc;

  typedef struct {
    logic [2:0] byp; int d0, d1, d2, lim; logic [2:0] hang; int spc; logic [2:0] spb;
    int n, l0, l1, l2, c0, c1, c2, dc, ec, el;
  } vec_t;
  vec_t tbl[11];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  // Advance one cycle, record what the DUT shows, then drive the engine responses.
  task automatic tick();
    logic [NL-1:0] ld;
    @(posedge clk); #1;
    cyc++;
    for (int i = 0; i < NL; i++)
      if (layer_start[i]) begin
        st_l.push_back(i); st_c.push_back(cyc);
        if (int'(cur_layer) != i) curl_bad = 1;
      end
    if ($countones(layer_start) > 1) onehot_bad = 1;
    if (done) done_q.push_back(cyc);
    if (error && err_cyc < 0) begin err_cyc = cyc; err_l = int'(err_layer); end
    ld = '0;
    for (int i = 0; i < NL; i++) begin
      if (cnt[i] > 0) begin
        cnt[i]--;
        if (cnt[i] == 0) begin ld[i] = 1'b1; cnt[i] = -1; end
      end
      if (layer_start[i]) cnt[i] = hang[i] ? -1 : dly[i];
    end
    if (cyc == spur_cyc) ld |= spur_bits;
    layer_done = ld;
  endtask

  task automatic clear_obs();
    st_l.delete(); st_c.delete(); done_q.delete();
    err_cyc = -1; err_l = 0; cyc = 0; spur_cyc = -1; spur_bits = '0;
    busy_drop = 0; onehot_bad = 0; curl_bad = 0;
    for (int i = 0; i < NL; i++) cnt[i] = -1;
    layer_done = '0;
  endtask

  // Timing model: layer launches one cycle after the previous event, finishes d cycles later.
  task automatic model(input logic [2:0] byp, input int d0, input int d1, input int d2,
                       input int lim, input logic [2:0] hg);
    int d[3];
    int t, launch;
    d[0] = d0; d[1] = d1; d[2] = d2;
    exp_l.delete(); exp_c.delete();
    exp_dc = -1; exp_ec = -1; exp_el = 0; t = 0;
    for (int i = 0; i < NL; i++) begin
      if (!byp[i]) begin
        launch = t + 1;
        exp_l.push_back(i); exp_c.push_back(launch);
        if (hg[i] || (lim != 0 && d[i] > lim)) begin
          exp_ec = launch + lim + 1; exp_el = i;
          break;
        end
        t = launch + d[i];
      end
    end
    if (exp_ec < 0) exp_dc = t + 1;
  endtask

  task automatic run_frame(input logic [2:0] byp, input int d0, input int d1, input int d2,
                           input int lim, input logic [2:0] hg, input int spc,
                           input logic [2:0] spb, input bit rs);
    clear_obs();
    dly[0] = d0; dly[1] = d1; dly[2] = d2; hang = hg;
    spur_cyc = spc; spur_bits = spb;
    bypass = byp; timeout_limit = TW'(lim); start = 1'b1;
    tick();
    start = 1'b0; bypass = ~byp;
    if (!busy && !error) busy_drop = 1;
    while (done_q.size() == 0 && err_cyc < 0 && cyc < 300) begin
      if (rs) start = ($urandom_range(0, 3) == 0);
      tick();
      if (!busy && !error) busy_drop = 1;
    end
    start = 1'b0;
  endtask

  task automatic check_frame(input string tag);
    int m;
    if (exp_dc >= 0) exp_fc++;
    chk({tag, " nstart"}, st_l.size(), exp_l.size());
    m = (st_l.size() < exp_l.size()) ? st_l.size() : exp_l.size();
    for (int k = 0; k < m; k++) begin
      chk($sformatf("%s start%0d layer", tag, k), st_l[k], exp_l[k]);
      chk($sformatf("%s start%0d cycle", tag, k), st_c[k], exp_c[k]);
    end
    chk({tag, " done_cyc"}, (done_q.size() > 0) ? done_q[0] : -1, exp_dc);
    chk({tag, " err_cyc"}, err_cyc, exp_ec);
    if (err_cyc >= 0) chk({tag, " err_layer"}, err_l, exp_el);
    chk({tag, " busy_drop"}, int'(busy_drop), 0);
    chk({tag, " onehot"}, int'(onehot_bad), 0);
    chk({tag, " cur_layer"}, int'(curl_bad), 0);
    chk({tag, " frame_count"}, int'(frame_count), exp_fc);
  endtask

  task automatic post_frame(input string tag);
    if (error) begin
      start = 1'b1; tick();
      chk({tag, " err_hold"}, int'(error), 1);
      chk({tag, " err_nostart"}, int'(layer_start), 0);
      chk({tag, " err_busy"}, int'(busy), 0);
      start = 1'b0; abort = 1'b1; tick(); abort = 1'b0;
      chk({tag, " err_clear"}, int'(error), 0);
    end else begin
      tick();
    end
    chk({tag, " idle_done"}, int'(done), 0);
    chk({tag, " idle_busy"}, int'(busy), 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " layer_start"}, int'(layer_start), 0);
    chk({tag, " cur_layer"}, int'(cur_layer), 0);
    chk({tag, " busy"}, int'(busy), 0);
    chk({tag, " done"}, int'(done), 0);
    chk({tag, " error"}, int'(error), 0);
    chk({tag, " err_layer"}, int'(err_layer), 0);
    chk({tag, " frame_count"}, int'(frame_count), 0);
  endtask

  initial begin
    logic [2:0] rb, rh;
    int rd0, rd1, rd2, rl;
    //          byp    d0 d1 d2 lim hang   spc spb    n  l0 l1 l2 c0 c1  c2  dc  ec  el
    tbl[0]  = '{3'b000, 5, 5, 5, 0, 3'b000, -1, 3'b000, 3, 0, 1, 2, 1, 7, 13, 19, -1, 0};
    tbl[1]  = '{3'b010, 5, 5, 5, 0, 3'b000, -1, 3'b000, 2, 0, 2, 0, 1, 7, 0,  13, -1, 0};
    tbl[2]  = '{3'b111, 5, 5, 5, 0, 3'b000, -1, 3'b000, 0, 0, 0, 0, 0, 0, 0,  1,  -1, 0};
    tbl[3]  = '{3'b101, 3, 2, 7, 0, 3'b000, -1, 3'b000, 1, 1, 0, 0, 1, 0, 0,  4,  -1, 0};
    tbl[4]  = '{3'b000, 8, 8, 8, 8, 3'b000, -1, 3'b000, 3, 0, 1, 2, 1, 10, 19, 28, -1, 0};
    tbl[5]  = '{3'b110, 2, 9, 9, 0, 3'b000, -1, 3'b000, 1, 0, 0, 0, 1, 0, 0,  4,  -1, 0};
    tbl[6]  = '{3'b011, 9, 9, 1, 0, 3'b000, -1, 3'b000, 1, 2, 0, 0, 1, 0, 0,  3,  -1, 0};
    tbl[7]  = '{3'b000, 2, 5, 5, 8, 3'b010, -1, 3'b000, 2, 0, 1, 0, 1, 4, 0,  -1, 13, 1};
    tbl[8]  = '{3'b000, 3, 9, 4, 5, 3'b000, -1, 3'b000, 2, 0, 1, 0, 1, 5, 0,  -1, 11, 1};
    tbl[9]  = '{3'b000, 1, 1, 1, 1, 3'b000, -1, 3'b000, 3, 0, 1, 2, 1, 3, 5,  7,  -1, 0};
    tbl[10] = '{3'b000, 5, 5, 5, 0, 3'b000, 3,  3'b110, 3, 0, 1, 2, 1, 7, 13, 19, -1, 0};

    rst = 1'b0; start = 1'b0; abort = 1'b0; cont_mode = 1'b0;
    bypass = '0; timeout_limit = '0; exp_fc = 0;
    clear_obs(); hang = '0;
    for (int i = 0; i < NL; i++) dly[i] = 1;
    repeat (3) tick();
    chk_all_zero("reset");
    rst = 1'b1; tick();

    for (int v = 0; v < 11; v++) begin
      exp_l.delete(); exp_c.delete();
      for (int k = 0; k < tbl[v].n; k++) begin
        exp_l.push_back(k == 0 ? tbl[v].l0 : (k == 1 ? tbl[v].l1 : tbl[v].l2));
        exp_c.push_back(k == 0 ? tbl[v].c0 : (k == 1 ? tbl[v].c1 : tbl[v].c2));
      end
      exp_dc = tbl[v].dc; exp_ec = tbl[v].ec; exp_el = tbl[v].el;
      run_frame(tbl[v].byp, tbl[v].d0, tbl[v].d1, tbl[v].d2, tbl[v].lim, tbl[v].hang,
                tbl[v].spc, tbl[v].spb, 1'b0);
      check_frame($sformatf("vec%0d", v));
      post_frame($sformatf("vec%0d", v));
    end

    // Continuous mode: four back-to-back frames, then abort in the fifth.
    clear_obs(); hang = '0;
    for (int i = 0; i < NL; i++) dly[i] = 1;
    bypass = '0; timeout_limit = '0; cont_mode = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    if (!busy) busy_drop = 1;
    while (cyc < 30) begin
      tick();
      if (!busy) busy_drop = 1;
    end
    abort = 1'b1; tick(); abort = 1'b0;
    chk("cont ndone", done_q.size(), 4);
    for (int k = 0; k < done_q.size() && k < 4; k++)
      chk($sformatf("cont done%0d cycle", k), done_q[k], 7 * (k + 1));
    chk("cont nstart", st_l.size(), 13);
    chk("cont busy_gap", int'(busy_drop), 0);
    exp_fc += 4;
    chk("cont abort frame_count", int'(frame_count), exp_fc);
    chk("cont abort busy", int'(busy), 0);
    chk("cont abort done", int'(done), 0);

    // Continuous mode with every layer bypassed: a done pulse every cycle.
    clear_obs(); bypass = '1; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick();
    abort = 1'b1; tick(); abort = 1'b0;
    cont_mode = 1'b0;
    chk("bypall ndone", done_q.size(), 3);
    chk("bypall nstart", st_l.size(), 0);
    exp_fc += 3;
    chk("bypall frame_count", int'(frame_count), exp_fc);
    chk("bypall done_after_abort", int'(done), 0);

    // Reset in the middle of WAIT.
    clear_obs(); hang = '0;
    for (int i = 0; i < NL; i++) dly[i] = 9;
    bypass = '0; start = 1'b1;
    tick(); start = 1'b0;
    repeat (3) tick();
    rst = 1'b0; tick();
    chk_all_zero("midreset");
    rst = 1'b1; exp_fc = 0; tick();

    for (int f = 0; f < 30; f++) begin
      rb = 3'($urandom_range(0, 7));
      rd0 = $urandom_range(1, 6); rd1 = $urandom_range(1, 6); rd2 = $urandom_range(1, 6);
      rl = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 7);
      rh = (rl != 0 && $urandom_range(0, 4) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      model(rb, rd0, rd1, rd2, rl, rh);
      run_frame(rb, rd0, rd1, rd2, rl, rh, -1, 3'b000, 1'b1);
      check_frame($sformatf("rnd%0d", f));
      post_frame($sformatf("rnd%0d", f));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
